// File: rtl/draw_pkg.sv
// Shared screen geometry and scheduler state encoding for the drawing pipeline.
// Imported by the redraw scheduler, its watchdog and the testbench.
package draw_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOR_W  = 3;
    localparam int TIMER_W  = 20;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BG_RUN     = 3'd1,
        ST_CHAR_START = 3'd2,
        ST_CHAR_RUN   = 3'd3,
        ST_DONE       = 3'd4
    } redraw_state_t;

endpackage

// File: rtl/redraw_watchdog.sv
// Cycle watchdog for a drawer pass: cleared on pass entry, counts while enabled,
// and flags expiry on the last allowed cycle.
module redraw_watchdog
    import draw_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 20'd200000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    // Saturates at expiry so a stalled scheduler can never wrap the counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TIMEOUT_CYCLES - 1'b1);

endmodule

// File: rtl/redraw_scheduler.sv
// Sequences screen updates: latches redraw requests, runs the map and sprite drawers
// in order, and owns the single registered VGA pixel-write port.
module redraw_scheduler
    import draw_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 20'd200000,
    parameter int                 STATE_W        = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               map_req,
    input  logic               spr_req,
    input  logic [STATE_W-1:0] gameState,
    output logic               bg_go,
    output logic [STATE_W-1:0] bg_state,
    input  logic               bg_done,
    input  logic               bg_plot,
    input  logic [X_W-1:0]     bg_x,
    input  logic [Y_W-1:0]     bg_y,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               char_go,
    input  logic               char_done,
    input  logic               char_plot,
    input  logic [X_W-1:0]     char_x,
    input  logic [Y_W-1:0]     char_y,
    input  logic [COLOR_W-1:0] char_color,
    output logic               vga_plot,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               busy,
    output logic               redraw_done,
    output logic               timeout_err
);

    redraw_state_t state, state_next;
    logic          pend_map, pend_spr;
    logic          take_map, take_spr, abort;
    logic          wd_clear, wd_enable, wd_expired;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A sprite request is also absorbed when the character pass starts, since that
    // pass already draws the latest sprite positions.
    always_comb begin
        state_next  = state;
        bg_go       = 1'b0;
        char_go     = 1'b0;
        redraw_done = 1'b0;
        take_map    = 1'b0;
        take_spr    = 1'b0;
        abort       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_map) begin
                    state_next = ST_BG_RUN;
                    take_map   = 1'b1;
                    take_spr   = 1'b1;
                end else if (pend_spr) begin
                    state_next = ST_CHAR_START;
                    take_spr   = 1'b1;
                end
            end
            ST_BG_RUN: begin
                bg_go = 1'b1;
                if (bg_done) begin
                    state_next = ST_CHAR_START;
                end else if (wd_expired) begin
                    state_next = ST_DONE;
                    abort      = 1'b1;
                end
            end
            ST_CHAR_START: begin
                char_go    = 1'b1;
                take_spr   = 1'b1;
                state_next = ST_CHAR_RUN;
            end
            ST_CHAR_RUN: begin
                if (char_done) begin
                    state_next = ST_DONE;
                end else if (wd_expired) begin
                    state_next = ST_DONE;
                    abort      = 1'b1;
                end
            end
            ST_DONE: begin
                redraw_done = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign wd_enable = (state == ST_BG_RUN) || (state == ST_CHAR_RUN);
    assign wd_clear  = (state_next != state) &&
                       ((state_next == ST_BG_RUN) || (state_next == ST_CHAR_RUN));

    redraw_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // New requests win over consumption in the same cycle so none is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_map    <= 1'b0;
            pend_spr    <= 1'b0;
            bg_state    <= '0;
            timeout_err <= 1'b0;
        end else begin
            pend_map <= map_req | (pend_map & ~take_map);
            pend_spr <= spr_req | (pend_spr & ~take_spr);
            if (take_map) begin
                bg_state <= gameState;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end else if (take_map) begin
                timeout_err <= 1'b0;
            end
        end
    end

    // Only the drawer that owns the current phase reaches the VGA port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_plot  <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
        end else begin
            case (state)
                ST_BG_RUN: begin
                    vga_plot  <= bg_plot;
                    vga_x     <= bg_x;
                    vga_y     <= bg_y;
                    vga_color <= bg_color;
                end
                ST_CHAR_START, ST_CHAR_RUN: begin
                    vga_plot  <= char_plot;
                    vga_x     <= char_x;
                    vga_y     <= char_y;
                    vga_color <= char_color;
                end
                default: vga_plot <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_redraw_scheduler.sv
// Self-checking bench for redraw_scheduler: directed table, randomized passes against a
// timeline model, and hand-written sequences for pre-emption, arbitration and reset.
module tb_redraw_scheduler;
    import draw_pkg::*;

    localparam logic [19:0] T_CYC = 20'd300;
    localparam int T = 300;
    localparam int P_IDLE = 0, P_BG = 1, P_CS = 2, P_CR = 3, P_DN = 4;
    localparam int K_MAP = 0, K_SPR = 1, K_BOTH = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic               map_req, spr_req;
    logic [3:0]         gameState;
    logic               bg_go, char_go, busy, redraw_done, timeout_err;
    logic [3:0]         bg_state;
    logic               bg_done, bg_plot, char_done, char_plot;
    logic [X_W-1:0]     bg_x, char_x, vga_x;
    logic [Y_W-1:0]     bg_y, char_y, vga_y;
    logic [COLOR_W-1:0] bg_color, char_color, vga_color;
    logic               vga_plot;

    int         compared = 0;
    int         mismatched = 0;
    logic [19:0] expPix;
    logic       errFlag;
    logic [3:0] lastBgState;

    typedef struct {
        int         kind;
        logic [3:0] gs;
        int         bgLat;
        int         chLat;
        bit         noBgDone;
        int         injSprK;
        bit         earlyCd;
        int         expBgGo;
        int         expCharGo;
        int         expDone;
        int         expDoneAt;
    } vec_t;

    vec_t vecs[8];

    redraw_scheduler #(.TIMEOUT_CYCLES(T_CYC), .STATE_W(4)) dut (
        .clock(clock), .reset(reset), .map_req(map_req), .spr_req(spr_req),
        .gameState(gameState), .bg_go(bg_go), .bg_state(bg_state), .bg_done(bg_done),
        .bg_plot(bg_plot), .bg_x(bg_x), .bg_y(bg_y), .bg_color(bg_color),
        .char_go(char_go), .char_done(char_done), .char_plot(char_plot),
        .char_x(char_x), .char_y(char_y), .char_color(char_color),
        .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .busy(busy), .redraw_done(redraw_done), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] aborted");
    end

    function automatic logic [29:0] snapshot();
        return {bg_go, char_go, busy, redraw_done, timeout_err, bg_state,
                vga_plot, vga_x, vga_y, vga_color};
    endfunction

    function automatic int phaseAt(int k, bit hasMap, int bgEnd, int csAt, int crEnd, int dnAt);
        if (hasMap && k >= 1 && k <= bgEnd) return P_BG;
        if (k == csAt) return P_CS;
        if (csAt >= 0 && k > csAt && k <= crEnd) return P_CR;
        if (k == dnAt) return P_DN;
        return P_IDLE;
    endfunction

    function automatic logic pick(int which);
        case (which)
            0:       return bg_go;
            1:       return char_go;
            default: return redraw_done;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int cyc, input logic [29:0] expv);
        logic [29:0] act;
        act = snapshot();
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %h required %h", name, cyc, act, expv);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    task automatic waitSignal(input string name, input int which, input int maxCycles, output int cycles);
        cycles = -1;
        for (int i = 0; i <= maxCycles; i++) begin
            if (pick(which)) begin
                cycles = i;
                break;
            end
            tick();
        end
        if (cycles < 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: got no response in %0d cycles, required one", name, maxCycles);
        end
    endtask

    task automatic clearInputs();
        map_req = 0; spr_req = 0; bg_done = 0; char_done = 0;
        bg_plot = 0; bg_x = '0; bg_y = '0; bg_color = '0;
        char_plot = 0; char_x = '0; char_y = '0; char_color = '0;
    endtask

    task automatic randomPlots();
        bg_plot    = 1'($urandom_range(0, 1));
        bg_x       = 9'($urandom_range(0, SCREEN_W - 1));
        bg_y       = 8'($urandom_range(0, SCREEN_H - 1));
        bg_color   = 3'($urandom);
        char_plot  = 1'($urandom_range(0, 1));
        char_x     = 9'($urandom_range(0, SCREEN_W - 1));
        char_y     = 8'($urandom_range(0, SCREEN_H - 1));
        char_color = 3'($urandom);
    endtask

    // One redraw pass; expected phases come from the request kind and drawer latencies.
    task automatic applyStimulus(input int kind, input logic [3:0] gs, input int bgLat,
                                 input int chLat, input bit noBgDone, input int injSprK,
                                 input bit earlyCd, output int bgGoSeen, output int charGoSeen,
                                 output int doneSeen, output int doneAt);
        bit          hasMap;
        int          bgEnd, csAt, crEnd, dnAt, ph, prevPh;
        logic [20:0] prevBg, prevCh;
        logic        expPlot;
        hasMap = (kind != K_SPR);
        if (hasMap && noBgDone) begin
            bgEnd = T; csAt = -1; crEnd = -1; dnAt = T + 1;
        end else if (hasMap) begin
            bgEnd = 1 + bgLat; csAt = bgEnd + 1; crEnd = csAt + chLat; dnAt = crEnd + 1;
        end else begin
            bgEnd = 0; csAt = 1; crEnd = csAt + chLat; dnAt = crEnd + 1;
        end
        bgGoSeen = 0; charGoSeen = 0; doneSeen = 0; doneAt = -1;
        map_req = hasMap; spr_req = (kind != K_MAP); gameState = gs;
        bg_done = 0; char_done = 0;
        randomPlots();
        prevBg = {bg_plot, bg_x, bg_y, bg_color};
        prevCh = {char_plot, char_x, char_y, char_color};
        prevPh = P_IDLE;
        for (int k = 0; k <= dnAt + 4; k++) begin
            tick();
            ph = phaseAt(k, hasMap, bgEnd, csAt, crEnd, dnAt);
            expPlot = 1'b0;
            if (prevPh == P_BG) begin
                expPlot = prevBg[20]; expPix = prevBg[19:0];
            end else if (prevPh == P_CS || prevPh == P_CR) begin
                expPlot = prevCh[20]; expPix = prevCh[19:0];
            end
            if (hasMap && k >= 1) begin
                lastBgState = gs;
                errFlag = noBgDone && (k >= dnAt);
            end
            checkOutput($sformatf("pass_kind%0d", kind), k,
                        {ph == P_BG, ph == P_CS, ph != P_IDLE, ph == P_DN, errFlag,
                         lastBgState, expPlot, expPix});
            if (bg_go) bgGoSeen++;
            if (char_go) charGoSeen++;
            if (redraw_done) begin
                doneSeen++;
                doneAt = k;
            end
            map_req   = 0;
            spr_req   = (k == injSprK);
            bg_done   = hasMap && !noBgDone && (k == bgEnd);
            char_done = (k == crEnd) || (earlyCd && k == csAt);
            if (k >= 1) gameState = 4'($urandom);
            randomPlots();
            prevBg = {bg_plot, bg_x, bg_y, bg_color};
            prevCh = {char_plot, char_x, char_y, char_color};
            prevPh = ph;
        end
        spr_req = 0; bg_done = 0; char_done = 0;
    endtask

    initial begin
        int bgGo, chGo, dn, dnAt, cyc;
        int kind, lat, clat, inj;
        bit nb, ec;
        logic [3:0] g;

        vecs[0] = '{K_MAP,  4'd3,  100, 20, 1'b0, -1, 1'b0, 101, 1, 1, 123};
        vecs[1] = '{K_SPR,  4'd5,  0,   7,  1'b0, -1, 1'b0, 0,   1, 1, 9};
        vecs[2] = '{K_BOTH, 4'd9,  4,   3,  1'b0, -1, 1'b0, 5,   1, 1, 10};
        vecs[3] = '{K_MAP,  4'd7,  10,  5,  1'b0, 5,  1'b0, 11,  1, 1, 18};
        vecs[4] = '{K_SPR,  4'd1,  0,   4,  1'b0, -1, 1'b1, 0,   1, 1, 6};
        vecs[5] = '{K_MAP,  4'd2,  0,   0,  1'b1, -1, 1'b0, 300, 0, 1, 301};
        vecs[6] = '{K_SPR,  4'd4,  0,   2,  1'b0, -1, 1'b0, 0,   1, 1, 4};
        vecs[7] = '{K_MAP,  4'd12, 0,   1,  1'b0, -1, 1'b0, 1,   1, 1, 4};

        reset = 1'b1;
        clearInputs();
        gameState = '0;
        expPix = '0; errFlag = 1'b0; lastBgState = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state", 0, '0);
        @(negedge clock) reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].kind, vecs[i].gs, vecs[i].bgLat, vecs[i].chLat,
                          vecs[i].noBgDone, vecs[i].injSprK, vecs[i].earlyCd,
                          bgGo, chGo, dn, dnAt);
            checkCount($sformatf("vec%0d_bg_go_cycles", i), bgGo, vecs[i].expBgGo);
            checkCount($sformatf("vec%0d_char_go_pulses", i), chGo, vecs[i].expCharGo);
            checkCount($sformatf("vec%0d_redraw_done_pulses", i), dn, vecs[i].expDone);
            checkCount($sformatf("vec%0d_redraw_done_cycle", i), dnAt, vecs[i].expDoneAt);
        end

        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 2);
            g    = 4'($urandom);
            lat  = $urandom_range(0, 30);
            clat = $urandom_range(1, 15);
            nb   = (kind != K_SPR) && ($urandom_range(0, 9) == 0);
            inj  = -1;
            if (kind != K_SPR && !nb && $urandom_range(0, 1) == 1) inj = $urandom_range(1, 1 + lat);
            ec   = 1'($urandom_range(0, 1));
            applyStimulus(kind, g, lat, clat, nb, inj, ec, bgGo, chGo, dn, dnAt);
            checkCount("rand_bg_go_cycles", bgGo, (kind == K_SPR) ? 0 : (nb ? T : lat + 1));
            checkCount("rand_char_go_pulses", chGo, nb ? 0 : 1);
            checkCount("rand_redraw_done_pulses", dn, 1);
            checkCount("rand_redraw_done_cycle", dnAt,
                       (kind == K_SPR) ? 2 + clat : (nb ? T + 1 : 3 + lat + clat));
        end

        // Map request arriving during a sprite-only pass waits for it to finish.
        clearInputs();
        gameState = 4'd6;
        spr_req = 1'b1; tick(); spr_req = 1'b0;
        waitSignal("spr_char_go", 1, 10, cyc);
        checkCount("spr_char_go_latency", cyc, 1);
        tick(); tick();
        map_req = 1'b1; tick(); map_req = 1'b0;
        tick();
        checkCount("no_preemption_bg_go", int'(bg_go), 0);
        char_done = 1'b1; tick(); char_done = 1'b0;
        waitSignal("spr_redraw_done", 2, 5, cyc);
        checkCount("spr_redraw_done_latency", cyc, 0);
        waitSignal("queued_map_bg_go", 0, 10, cyc);
        checkCount("queued_map_start_delay", cyc, 2);
        checkCount("queued_map_bg_state", int'(bg_state), 6);
        gameState = 4'd13;
        bg_done = 1'b1; tick(); bg_done = 1'b0;
        waitSignal("queued_map_char_go", 1, 3, cyc);
        tick();
        char_done = 1'b1; tick(); char_done = 1'b0;
        waitSignal("queued_map_redraw_done", 2, 5, cyc);
        checkCount("bg_state_held_mid_pass", int'(bg_state), 6);
        repeat (3) tick();
        checkCount("idle_after_two_passes", int'(busy), 0);

        // Arbitration: owner's pixel forwarded one cycle later, the other drawer dropped.
        clearInputs();
        gameState = 4'd0;
        map_req = 1'b1; tick(); map_req = 1'b0;
        waitSignal("pixel_bg_go", 0, 5, cyc);
        bg_plot = 1'b1; bg_x = 9'd319; bg_y = 8'd239; bg_color = 3'b101;
        char_plot = 1'b1; char_x = 9'd10; char_y = 8'd20; char_color = 3'b010;
        tick();
        checkCount("bg_pixel_forwarded", int'({vga_plot, vga_x, vga_y, vga_color}),
                   int'({1'b1, 9'd319, 8'd239, 3'b101}));
        bg_plot = 1'b0;
        tick();
        checkCount("char_plot_dropped_in_bg", int'(vga_plot), 0);
        bg_done = 1'b1; tick(); bg_done = 1'b0;
        tick();
        checkCount("char_pixel_forwarded", int'({vga_plot, vga_x, vga_y, vga_color}),
                   int'({1'b1, 9'd10, 8'd20, 3'b010}));
        bg_plot = 1'b1; char_plot = 1'b0;
        tick();
        checkCount("bg_plot_dropped_in_char", int'({vga_plot, vga_x, vga_y, vga_color}),
                   int'({1'b0, 9'd10, 8'd20, 3'b010}));
        bg_plot = 1'b0;
        char_done = 1'b1; tick(); char_done = 1'b0;
        waitSignal("pixel_redraw_done", 2, 5, cyc);
        tick();

        // Reset in the middle of a background pass clears everything at once.
        clearInputs();
        gameState = 4'd11;
        map_req = 1'b1; tick(); map_req = 1'b0;
        waitSignal("reset_pass_bg_go", 0, 5, cyc);
        bg_plot = 1'b1; bg_x = 9'd100; bg_y = 8'd50; bg_color = 3'b111;
        spr_req = 1'b1; tick(); spr_req = 1'b0; bg_plot = 1'b0;
        checkCount("bg_state_before_reset", int'(bg_state), 11);
        #2 reset = 1'b1;
        #1 checkOutput("mid_pass_reset", 0, '0);
        #3 reset = 1'b0;
        repeat (4) tick();
        checkCount("pending_lost_after_reset", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
